enigma_rotor_stage: RTL and testbench
=====================================

Name: enigma_rotor_stage

Overview:
- Parametrised, clocked Enigma rotor stage that replaces the fixed combinational per-rotor forward and inverse modules.
- Holds a loadable wiring table and its automatically built inverse, a rotor position, a ring setting and a turnover notch.
- Encodes one letter per handshake in either direction, with 1-cycle registered latency.
- Three instances chain between the plugboard and the reflector. The carry of each stage drives step_in of the next.

Parameters:
ALPHA, 26, alphabet size; letters are encoded 1..ALPHA, and 0 means invalid
LW, 5, letter/position width; must satisfy 2^LW > ALPHA
NOTCH, 21, 0-based position at which turnover occurs when stepping from NOTCH to NOTCH+1 (21 = V, rotor III)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  wiring write strobe
cfg_addr  in  LW  wiring input letter, 1..ALPHA
cfg_data  in  LW  wiring output letter, 1..ALPHA
set_we  in  1  load position and ring
set_pos  in  LW  new position, 0..ALPHA-1
set_ring  in  LW  new ring setting, 0..ALPHA-1
step_in  in  1  advance position by one this cycle
carry_out  out  1  registered 1-cycle turnover pulse
in_valid  in  1  letter offered
in_ready  out  1  stage accepts letter
in_letter  in  LW  input letter
in_dir  in  1  direction: 0 = forward, 1 = inverse (return path)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_letter  out  LW  encoded letter; 0 on error
pos  out  LW  current position, for display
err  out  1  sticky flag for an invalid input letter or invalid cfg write

Behaviour:
- Reset (async, rst_n=0):
  - pos=0, ring=0.
  - fwd[i]=inv[i]=i for all i (identity wiring).
  - out_valid=0, out_letter=0, carry_out=0, err=0.
- Config write:
  - On cfg_we, fwd[cfg_addr]<=cfg_data and inv[cfg_data]<=cfg_addr in the same cycle.
  - If cfg_addr or cfg_data is 0 or >ALPHA, the write is ignored and err<=1.
  - While cfg_we or set_we is high, in_ready=0.
  - Software loads a permutation. Non-permutation contents give undefined encoding but must not lock up the stage.
- set_we:
  - pos<=set_pos mod ALPHA, ring<=set_ring mod ALPHA.
  - Has priority over step_in in the same cycle; carry_out=0 in that cycle.
- Stepping:
  - On step_in, pos<=(pos+1) mod ALPHA; 25 wraps to 0.
  - carry_out<=1 for exactly one cycle iff pos==NOTCH before the step.
  - Otherwise carry_out<=0.
- Handshake:
  - in_ready = !cfg_we && !set_we && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - out_valid and out_letter hold stable while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and no new accept occurs.
- Encoding, latency 1 cycle from accept:
  - Uses pos and ring as they were in the accept cycle (pre-step, if step_in is coincident).
  - Let s = pos - ring, computed mod ALPHA. Then e = ((in_letter-1+s) mod ALPHA)+1.
  - Look up t = fwd[e] if in_dir=0, else inv[e].
  - out_letter = ((t-1-s) mod ALPHA)+1.
  - All intermediates are LW+1 bits. The mod uses a conditional add/subtract of ALPHA, not a divider.
- Invalid in_letter (0 or >ALPHA): the letter is still accepted, out_letter=0, and err<=1.
- err clears only on reset.
- Reset mid-transfer discards any pending out_valid data.

Decomposition:
- enigma_pkg holds:
  - ALPHA and the letter width
  - LETTER_INVALID=0
  - the standard rotor wiring constants for I..V and their notch positions, used by benches and top-level init
- Sub-module rotor_mod_add:
  - combinational (a ± b) mod ALPHA on 0-based operands with a single correction step.
  - instantiated for the entry offset, the exit offset and position increment.

Test Plan:
- Identity after reset: pos=0, ring=0, in_letter=5 in both directions -> out_letter=5 one cycle after accept; carry_out stays 0.
- Load rotor III wiring (BDFHJLCPRTXVZNYEIWGAKMUSQO), pos=0, ring=0:
  - fwd A(1) -> B(2).
  - inv B(2) -> A(1).
  - Round trip fwd then inv for all 26 letters returns the input.
- Offset: rotor III, pos=1, ring=0, fwd A(1) -> e=B -> t=D(4) -> out=C(3).
  - Same result with pos=2, ring=1.
- Stepping and notch:
  - From pos=20, pulse step_in 6 times -> pos 21..26 mod 26.
  - carry_out is high exactly on the cycle after the step from 21 to 22.
  - Step from 25 gives pos=0 and carry_out=0.
  - set_we coincident with step_in loads set_pos with no carry.
- Backpressure: hold out_ready=0 with in_valid=1 -> one letter accepted, then in_ready=0, and out_letter is held stable for 5 cycles. Release -> the next letter is accepted the same cycle.
- Errors and reset: in_letter=0 -> out_letter=0 and err=1 (sticky). cfg_addr=27 write is ignored and the table is unchanged. rst_n low while out_valid=1 -> out_valid=0 immediately and the tables return to identity.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet geometry, standard rotor wirings and notches.
package enigma_pkg;

    localparam int ALPHA_STD      = 26;
    localparam int LW_STD         = 5;
    localparam int LETTER_INVALID = 0;

    localparam string ROTOR_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam string ROTOR_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam string ROTOR_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam string ROTOR_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    localparam string ROTOR_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";

    // 0-based notch positions (Q, E, V, J, Z)
    localparam int NOTCH_I   = 16;
    localparam int NOTCH_II  = 4;
    localparam int NOTCH_III = 21;
    localparam int NOTCH_IV  = 9;
    localparam int NOTCH_V   = 25;

    function automatic logic letter_ok(input int l, input int alpha);
        return (l >= 1) && (l <= alpha);
    endfunction

endpackage

// File: rtl/rotor_mod_add.sv
// Combinational (a +/- b) mod ALPHA on 0-based operands, one correction step.
module rotor_mod_add #(
    parameter int ALPHA = 26,
    parameter int LW    = 5
) (
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic          sub,
    output logic [LW-1:0] y
);

    localparam logic [LW:0] AL = (LW+1)'(ALPHA);

    logic [LW:0] ax;
    logic [LW:0] bx;
    logic [LW:0] raw;
    logic [LW:0] fix;

    always_comb begin
        ax  = {1'b0, a};
        bx  = {1'b0, b};
        raw = '0;
        fix = '0;
        y   = '0;
        if (sub) begin
            raw = ax - bx;
            fix = raw + AL;
            y   = (ax < bx) ? fix[LW-1:0] : raw[LW-1:0];
        end else begin
            raw = ax + bx;
            fix = raw - AL;
            y   = (raw >= AL) ? fix[LW-1:0] : raw[LW-1:0];
        end
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// One clocked Enigma rotor: loadable wiring with auto-built inverse,
// position/ring/notch stepping and a 1-cycle registered encode path.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int ALPHA = ALPHA_STD,
    parameter int LW    = LW_STD,
    parameter int NOTCH = NOTCH_III
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [LW-1:0] cfg_addr,
    input  logic [LW-1:0] cfg_data,
    input  logic          set_we,
    input  logic [LW-1:0] set_pos,
    input  logic [LW-1:0] set_ring,
    input  logic          step_in,
    output logic          carry_out,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] in_letter,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] out_letter,
    output logic [LW-1:0] pos,
    output logic          err
);

    localparam int          DEPTH   = 2**LW;
    localparam logic [LW-1:0] AL    = LW'(ALPHA);
    localparam logic [LW-1:0] NOTCH_L = LW'(NOTCH);
    localparam logic [LW-1:0] ONE   = LW'(1);

    logic [LW-1:0] fwd [DEPTH];
    logic [LW-1:0] inv [DEPTH];
    logic [LW-1:0] ring;

    logic          in_ok;
    logic          cfg_ok;
    logic          accept;
    logic [LW-1:0] shift;
    logic [LW-1:0] in0;
    logic [LW-1:0] e0;
    logic [LW-1:0] e;
    logic [LW-1:0] t;
    logic [LW-1:0] t0;
    logic [LW-1:0] x0;
    logic [LW-1:0] result;
    logic [LW-1:0] pos_inc;
    logic [LW-1:0] pos_set;
    logic [LW-1:0] ring_set;

    assign in_ok  = letter_ok(int'(in_letter), ALPHA);
    assign cfg_ok = letter_ok(int'(cfg_addr), ALPHA)
                 && letter_ok(int'(cfg_data), ALPHA);

    assign in_ready = !cfg_we && !set_we && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Invalid letters are forced to 0 so the adders stay in range.
    assign in0 = in_ok ? in_letter - ONE : '0;

    rotor_mod_add #(.ALPHA(ALPHA), .LW(LW)) u_shift (
        .a   (pos),
        .b   (ring),
        .sub (1'b1),
        .y   (shift)
    );

    rotor_mod_add #(.ALPHA(ALPHA), .LW(LW)) u_entry (
        .a   (in0),
        .b   (shift),
        .sub (1'b0),
        .y   (e0)
    );

    assign e = e0 + ONE;
    assign t = in_dir ? inv[e] : fwd[e];

    // Table entries are always 1..ALPHA; guard keeps the exit adder bounded.
    assign t0 = (t != '0 && t <= AL) ? t - ONE : '0;

    rotor_mod_add #(.ALPHA(ALPHA), .LW(LW)) u_exit (
        .a   (t0),
        .b   (shift),
        .sub (1'b1),
        .y   (x0)
    );

    assign result = in_ok ? x0 + ONE : LW'(LETTER_INVALID);

    rotor_mod_add #(.ALPHA(ALPHA), .LW(LW)) u_step (
        .a   (pos),
        .b   (ONE),
        .sub (1'b0),
        .y   (pos_inc)
    );

    assign pos_set  = (set_pos  >= AL) ? set_pos  - AL : set_pos;
    assign ring_set = (set_ring >= AL) ? set_ring - AL : set_ring;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd[i] <= LW'(i);
                inv[i] <= LW'(i);
            end
        end else if (cfg_we && cfg_ok) begin
            fwd[cfg_addr] <= cfg_data;
            inv[cfg_data] <= cfg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos       <= '0;
            ring      <= '0;
            carry_out <= 1'b0;
        end else if (set_we) begin
            pos       <= pos_set;
            ring      <= ring_set;
            carry_out <= 1'b0;
        end else if (step_in) begin
            pos       <= pos_inc;
            carry_out <= (pos == NOTCH_L);
        end else begin
            carry_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_letter <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_letter <= result;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((cfg_we && !cfg_ok) || (accept && !in_ok)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Randomised and directed bench for enigma_rotor_stage against a letter-level model.
module tb_enigma_rotor_stage;
    import enigma_pkg::*;

    localparam int A  = 26;
    localparam int NT = 21;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [4:0] cfg_data;
    logic       set_we;
    logic [4:0] set_pos;
    logic [4:0] set_ring;
    logic       step_in;
    logic       carry_out;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_letter;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_letter;
    logic [4:0] pos;
    logic       err;

    enigma_rotor_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .set_we     (set_we),
        .set_pos    (set_pos),
        .set_ring   (set_ring),
        .step_in    (step_in),
        .carry_out  (carry_out),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_letter  (in_letter),
        .in_dir     (in_dir),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_letter (out_letter),
        .pos        (pos),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    int fwd_m [1:A];
    int inv_m [1:A];
    int pos_m, ring_m, ol_m;
    bit err_m, ov_m, carry_m;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic reset_model();
        for (int i = 1; i <= A; i++) begin
            fwd_m[i] = i;
            inv_m[i] = i;
        end
        pos_m = 0; ring_m = 0; ol_m = 0;
        err_m = 0; ov_m = 0; carry_m = 0;
    endtask

    function automatic int model_enc(input int l, input bit d);
        int s, e, t;
        if (l < 1 || l > A) return 0;
        s = (pos_m - ring_m + A) % A;
        e = (l - 1 + s) % A + 1;
        t = d ? inv_m[e] : fwd_m[e];
        return (t - 1 - s + A) % A + 1;
    endfunction

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic cycle_chk();
        bit rdy, acc;
        int ca, cd;
        #1;
        rdy = !cfg_we && !set_we && (!ov_m || out_ready);
        check("in_ready", int'(in_ready), int'(rdy));
        acc = in_valid && rdy;
        if (acc) begin
            ol_m = model_enc(int'(in_letter), in_dir);
            ov_m = 1;
            if (ol_m == 0) err_m = 1;
        end else if (out_ready) begin
            ov_m = 0;
        end
        if (cfg_we) begin
            ca = int'(cfg_addr);
            cd = int'(cfg_data);
            if (ca >= 1 && ca <= A && cd >= 1 && cd <= A) begin
                fwd_m[ca] = cd;
                inv_m[cd] = ca;
            end else begin
                err_m = 1;
            end
        end
        if (set_we) begin
            pos_m   = int'(set_pos) % A;
            ring_m  = int'(set_ring) % A;
            carry_m = 0;
        end else if (step_in) begin
            carry_m = (pos_m == NT);
            pos_m   = (pos_m + 1) % A;
        end else begin
            carry_m = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(ov_m));
        if (ov_m) check("out_letter", int'(out_letter), ol_m);
        check("pos", int'(pos), pos_m);
        check("carry_out", int'(carry_out), int'(carry_m));
        check("err", int'(err), int'(err_m));
    endtask

    task automatic send(input int l, input bit d);
        in_valid  = 1'b1;
        in_letter = 5'(l);
        in_dir    = d;
        out_ready = 1'b1;
        cycle_chk();
        in_valid  = 1'b0;
    endtask

    task automatic load_pr(input int p, input int r);
        set_we   = 1'b1;
        set_pos  = 5'(p);
        set_ring = 5'(r);
        cycle_chk();
        set_we   = 1'b0;
    endtask

    initial begin
        string w;
        int    x, held, exp2;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        set_we = 1'b0; set_pos = '0; set_ring = '0; step_in = 1'b0;
        in_valid = 1'b0; in_letter = '0; in_dir = 1'b0; out_ready = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pos", int'(pos), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_letter", int'(out_letter), 0);
        check("rst_carry", int'(carry_out), 0);
        check("rst_err", int'(err), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        send(5, 1'b0);
        check("ident_fwd", int'(out_letter), 5);
        send(5, 1'b1);
        check("ident_inv", int'(out_letter), 5);
        check("ident_carry", int'(carry_out), 0);

        w = ROTOR_III;
        cfg_we = 1'b1;
        for (int i = 0; i < A; i++) begin
            cfg_addr = 5'(i + 1);
            cfg_data = 5'(int'(w[i]) - 64);
            cycle_chk();
        end
        cfg_we = 1'b0;

        send(1, 1'b0);
        check("iii_fwd_A", int'(out_letter), 2);
        send(2, 1'b1);
        check("iii_inv_B", int'(out_letter), 1);
        for (int l = 1; l <= A; l++) begin
            send(l, 1'b0);
            x = ol_m;
            send(x, 1'b1);
            check("round_trip", int'(out_letter), l);
        end

        load_pr(1, 0);
        send(1, 1'b0);
        check("offset_p1r0", int'(out_letter), 3);
        load_pr(2, 1);
        send(1, 1'b0);
        check("offset_p2r1", int'(out_letter), 3);

        load_pr(20, 0);
        step_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle_chk();
            check("step_pos", int'(pos), (20 + k) % A);
            check("step_carry", int'(carry_out), (k == 2) ? 1 : 0);
        end
        step_in = 1'b0;
        cycle_chk();
        check("carry_pulse_end", int'(carry_out), 0);

        load_pr(21, 0);
        set_we = 1'b1; set_pos = 5'd7; set_ring = 5'd0; step_in = 1'b1;
        cycle_chk();
        check("set_over_step_pos", int'(pos), 7);
        check("set_over_step_carry", int'(carry_out), 0);
        set_pos = 5'd30;
        step_in = 1'b0;
        cycle_chk();
        check("set_pos_mod", int'(pos), 4);
        set_we = 1'b0;

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_letter = 5'd3;
        in_dir    = 1'b0;
        cycle_chk();
        held = ol_m;
        in_letter = 5'd7;
        for (int k = 0; k < 5; k++) begin
            cycle_chk();
            check("bp_hold", int'(out_letter), held);
            check("bp_valid", int'(out_valid), 1);
        end
        exp2 = model_enc(7, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(in_ready), 1);
        cycle_chk();
        check("bp_next", int'(out_letter), exp2);
        in_valid = 1'b0;
        cycle_chk();

        load_pr(0, 0);
        send(0, 1'b0);
        check("inv_letter_out", int'(out_letter), 0);
        check("inv_letter_err", int'(err), 1);
        send(9, 1'b0);
        check("err_sticky", int'(err), 1);
        cfg_we = 1'b1; cfg_addr = 5'd27; cfg_data = 5'd3;
        cycle_chk();
        cfg_addr = 5'd1; cfg_data = 5'd0;
        cycle_chk();
        cfg_we = 1'b0;
        send(1, 1'b0);
        check("bad_cfg_ignored", int'(out_letter), 2);

        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_letter = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(1, A));
            in_dir    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step_in   = 1'($urandom_range(0, 1));
            set_we    = ($urandom_range(0, 15) == 0);
            set_pos   = 5'($urandom_range(0, 31));
            set_ring  = 5'($urandom_range(0, 31));
            cfg_we    = ($urandom_range(0, 24) == 0);
            cfg_addr  = 5'($urandom_range(0, 27));
            cfg_data  = 5'($urandom_range(0, 27));
            cycle_chk();
        end
        in_valid = 1'b0; step_in = 1'b0; set_we = 1'b0; cfg_we = 1'b0;
        out_ready = 1'b1;
        cycle_chk();

        load_pr(0, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_letter = 5'd4;
        in_dir    = 1'b0;
        cycle_chk();
        in_valid = 1'b0;
        check("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_letter", int'(out_letter), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_pos", int'(pos), 0);
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(1, 1'b0);
        check("rst_ident_fwd", int'(out_letter), 1);
        send(2, 1'b1);
        check("rst_ident_inv", int'(out_letter), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
